// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - operand/result handshake bundle for adder_pipe
interface adder_pipe_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - chunked add/subtract pipeline, one CW-bit chunk resolved per stage
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers: valid, operands (upper chunks still to be consumed),
  // partial sum (chunks 0..k resolved), and the carry out of chunk k.
  logic             v_r  [STAGES];
  logic [WIDTH-1:0] a_r  [STAGES];
  logic [WIDTH-1:0] bb_r [STAGES];
  logic [WIDTH-1:0] s_r  [STAGES];
  logic             c_r  [STAGES];
  logic             zero_r;

  logic             v_nx  [STAGES];
  logic [WIDTH-1:0] a_nx  [STAGES];
  logic [WIDTH-1:0] bb_nx [STAGES];
  logic [WIDTH-1:0] s_nx  [STAGES];
  logic             c_nx  [STAGES];

  logic [WIDTH-1:0] bb0;
  logic             c0;
  logic             adv;

  // Subtract is A + ~B + 1; carry-in is forced to 1 so cin is ignored in that mode.
  assign bb0 = bus.sub ? ~bus.b : bus.b;
  assign c0  = bus.sub | bus.cin;

  // The whole pipe moves together whenever the output slot is free or being drained.
  assign adv          = !v_r[LAST] || bus.out_ready;
  assign bus.in_ready = adv;

  // Next state of every stage: stage 0 resolves chunk 0 from the incoming operands,
  // stage k resolves chunk k from stage k-1 and passes the lower chunks through.
  always_comb begin
    logic [CW:0] part;
    part     = {1'b0, bus.a[CW-1:0]} + {1'b0, bb0[CW-1:0]} + {{CW{1'b0}}, c0};
    v_nx[0]  = bus.in_valid;
    a_nx[0]  = bus.a;
    bb_nx[0] = bb0;
    s_nx[0]  = '0;
    s_nx[0][CW-1:0] = part[CW-1:0];
    c_nx[0]  = part[CW];
    for (int k = 1; k < STAGES; k++) begin
      part     = {1'b0, a_r[k-1][k*CW +: CW]} + {1'b0, bb_r[k-1][k*CW +: CW]}
               + {{CW{1'b0}}, c_r[k-1]};
      v_nx[k]  = v_r[k-1];
      a_nx[k]  = a_r[k-1];
      bb_nx[k] = bb_r[k-1];
      s_nx[k]  = s_r[k-1];
      s_nx[k][k*CW +: CW] = part[CW-1:0];
      c_nx[k]  = part[CW];
    end
  end

  // Stage registers shift in lockstep on advance; bubbles are kept, not collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]  <= 1'b0;
        a_r[k]  <= '0;
        bb_r[k] <= '0;
        s_r[k]  <= '0;
        c_r[k]  <= 1'b0;
      end
      zero_r <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]  <= v_nx[k];
        a_r[k]  <= a_nx[k];
        bb_r[k] <= bb_nx[k];
        s_r[k]  <= s_nx[k];
        c_r[k]  <= c_nx[k];
      end
      zero_r <= (s_nx[LAST] == '0);
    end
  end

  // The last stage register is the output; overflow uses the sign of the captured B'.
  assign bus.out_valid = v_r[LAST];
  assign bus.sum       = s_r[LAST];
  assign bus.cout      = c_r[LAST];
  assign bus.zero      = zero_r;
  assign bus.ovf       = (a_r[LAST][WIDTH-1] == bb_r[LAST][WIDTH-1])
                      && (s_r[LAST][WIDTH-1] != a_r[LAST][WIDTH-1]);

endmodule
